// File: rtl/sram_pkg.sv
// Shared definitions for the external asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned DATA_W_DEF = 16;

  // Legal range for the per-access strobe length in clock cycles.
  localparam int unsigned WAIT_MIN = 1;
  localparam int unsigned WAIT_MAX = 15;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACCESS,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_e;

  // Width of the strobe down-counter: enough bits to hold WAIT_CYCLES.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/sram_dat_io.sv
// Bidirectional SRAM data pads: registered output enable, registered output
// data and a registered (capture-enabled) input, mirroring an iCE40 SB_IO
// configured with output/OE/input registers so the tristate timing stays in
// the IOBs. Callers present next-cycle values; the pad registers add the
// single register stage.
module sram_dat_io #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              oe_d_i,
  input  logic              dout_ld_i,
  input  logic [DATA_W-1:0] dout_i,
  input  logic              cap_i,
  output logic [DATA_W-1:0] din_o,
  inout  wire  [DATA_W-1:0] dat_io
);

  logic              oe_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] din_q;

  // Pad registers; reset releases the bus on the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
      din_q  <= '0;
    end else begin
      oe_q <= oe_d_i;
      if (dout_ld_i) dout_q <= dout_i;
      if (cap_i)     din_q  <= dat_io;
    end
  end

  assign dat_io = oe_q ? dout_q : 'z;
  assign din_o  = din_q;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port controller for the external asynchronous SRAM: one read or
// write at a time over valid/ready, with registered active-low chip controls
// and a configurable strobe length.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ADR,
  inout  wire  [DATA_W-1:0] DAT,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic              RAMCS
);

  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES out of range 1..15");
  end

  localparam int unsigned     CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [ADDR_W-1:0] adr_q;
  logic              cs_q, oe_q, we_q;
  logic              accept;
  logic              dat_oe_d;
  logic              rd_cap;

  assign accept = (state_q == IDLE) && ready_q && req_valid;

  // Next-state and strobe-counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_we ? WR_SETUP : RD_ACCESS;
          cnt_d   = CNT_LOAD;
        end
      end
      RD_ACCESS: begin
        if (cnt_q == '0) state_d = RD_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RD_DONE:  state_d = IDLE;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so every pin is glitch-free
  // and changes exactly on the edge that enters the corresponding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      adr_q       <= '0;
      cs_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (accept) adr_q <= req_addr;
      ready_q     <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RD_DONE);
      cs_q        <= !(state_d inside {RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD});
      oe_q        <= (state_d != RD_ACCESS);
      we_q        <= (state_d != WR_PULSE);
    end
  end

  // The pad registers take next-state values, so their outputs line up with
  // the control registers above; read data lands in the pad input register on
  // the edge that ends the last RD_ACCESS cycle and serves as rsp_rdata.
  assign dat_oe_d = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
  assign rd_cap   = (state_q == RD_ACCESS) && (cnt_q == '0);

  sram_dat_io #(
    .DATA_W (DATA_W)
  ) u_dat_io (
    .clk       (clk),
    .rst       (rst),
    .oe_d_i    (dat_oe_d),
    .dout_ld_i (accept),
    .dout_i    (req_wdata),
    .cap_i     (rd_cap),
    .din_o     (rsp_rdata),
    .dat_io    (DAT)
  );

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign ADR       = adr_q;
  assign RAMCS     = cs_q;
  assign RAMOE     = oe_q;
  assign RAMWE     = we_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: cycle-accurate checks at WAIT_CYCLES=2 against
// an SRAM model, plus strobe-width and read-data checks at WAIT_CYCLES=1 and 15.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: WAIT_CYCLES = 2
  logic        a_valid, a_ready, a_we, a_rsp;
  logic [17:0] a_addr, a_adr;
  logic [15:0] a_wdata, a_rdata;
  logic        a_oe, a_we_n, a_cs;
  wire  [15:0] a_dat;

  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp), .rsp_rdata(a_rdata),
    .ADR(a_adr), .DAT(a_dat), .RAMOE(a_oe), .RAMWE(a_we_n), .RAMCS(a_cs)
  );

  logic [15:0] mem [0:262143];
  assign a_dat = (!a_cs && !a_oe && a_we_n) ? mem[a_adr] : 'z;
  always @(posedge clk) if (!a_cs && !a_we_n) mem[a_adr] <= a_dat;

  // Instances B (W=1) and C (W=15) share request fields, separate valids.
  logic        s_we;
  logic [17:0] s_addr;
  logic [15:0] s_wdata;
  logic        b_valid, b_ready, b_rsp, b_oe, b_we_n, b_cs;
  logic        c_valid, c_ready, c_rsp, c_oe, c_we_n, c_cs;
  logic [15:0] b_rdata, c_rdata;
  logic [17:0] b_adr, c_adr;
  wire  [15:0] b_dat, c_dat;

  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(s_we),
    .req_addr(s_addr), .req_wdata(s_wdata), .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
    .ADR(b_adr), .DAT(b_dat), .RAMOE(b_oe), .RAMWE(b_we_n), .RAMCS(b_cs)
  );
  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(15)) u_c (
    .clk(clk), .rst(rst), .req_valid(c_valid), .req_ready(c_ready), .req_we(s_we),
    .req_addr(s_addr), .req_wdata(s_wdata), .rsp_valid(c_rsp), .rsp_rdata(c_rdata),
    .ADR(c_adr), .DAT(c_dat), .RAMOE(c_oe), .RAMWE(c_we_n), .RAMCS(c_cs)
  );

  // B/C memories return a fixed function of the address.
  assign b_dat = (!b_cs && !b_oe && b_we_n) ? (b_adr[15:0] ^ 16'h5A5A) : 'z;
  assign c_dat = (!c_cs && !c_oe && c_we_n) ? (c_adr[15:0] ^ 16'h5A5A) : 'z;

  // Bus monitors on the falling edge.
  int a_rsp_cnt = 0, a_bad = 0;
  int b_oe_run = 0, b_we_run = 0, b_oe_w = 0, b_we_w = 0;
  int c_oe_run = 0, c_we_run = 0, c_oe_w = 0, c_we_w = 0;
  logic a_drv;
  assign a_drv = u_a.u_dat_io.oe_q;

  always @(negedge clk) begin
    if (a_rsp) a_rsp_cnt++;
    if (!a_oe && !a_we_n) a_bad++;
    if (a_drv && !a_oe) a_bad++;
    if (!b_oe) b_oe_run++; else if (b_oe_run != 0) begin b_oe_w = b_oe_run; b_oe_run = 0; end
    if (!b_we_n) b_we_run++; else if (b_we_run != 0) begin b_we_w = b_we_run; b_we_run = 0; end
    if (!c_oe) c_oe_run++; else if (c_oe_run != 0) begin c_oe_w = c_oe_run; c_oe_run = 0; end
    if (!c_we_n) c_we_run++; else if (c_we_run != 0) begin c_we_w = c_we_run; c_we_run = 0; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on A, wait (bounded) for ready, take the handshake edge.
  // Returns in cycle 1 of the access; valid is left high when keep is set.
  task automatic a_issue(input bit we, input logic [17:0] addr, input logic [15:0] data,
                         input bit keep, output int waited);
    a_we = we; a_addr = addr; a_wdata = data; a_valid = 1'b1;
    waited = 0;
    while (!a_ready && waited < 40) begin tick(); waited++; end
    if (!a_ready) chk("a_accept_timeout", 32'd0, 32'd1);
    tick();
    if (!keep) a_valid = 1'b0;
  endtask

  // One full access on B (sel=0) or C (sel=1); returns captured read data.
  task automatic bc_op(input bit sel, input bit we, input logic [17:0] addr,
                       input logic [15:0] data, output logic [15:0] rd, output bit ok);
    int n;
    bit seen;
    s_we = we; s_addr = addr; s_wdata = data;
    if (sel) c_valid = 1'b1; else b_valid = 1'b1;
    n = 0;
    while (!(sel ? c_ready : b_ready) && n < 40) begin tick(); n++; end
    ok = sel ? c_ready : b_ready;
    tick();
    b_valid = 1'b0; c_valid = 1'b0;
    seen = 1'b0; rd = '0; n = 0;
    while (!(sel ? c_ready : b_ready) && n < 60) begin
      if (sel ? c_rsp : b_rsp) begin seen = 1'b1; rd = sel ? c_rdata : b_rdata; end
      tick(); n++;
    end
    ok = ok && (sel ? c_ready : b_ready) && (we || seen);
  endtask

  logic [2:0] wr_ctl [1:5] = '{3'b011, 3'b010, 3'b010, 3'b011, 3'b111};
  logic       wr_drv [1:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       wr_rdy [1:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0] rd_ctl [1:4] = '{3'b001, 3'b001, 3'b111, 3'b111};
  logic       rd_rsp [1:4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       rd_rdy [1:4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int bad;
    logic [15:0] rd;
    bit ok;
    rst = 1'b1;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; c_valid = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    repeat (3) tick();

    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_ctl", 32'({a_cs, a_oe, a_we_n}), 32'b111);
    chk("rst_adr", 32'(a_adr), 32'd0);
    chk("rst_rdata", 32'(a_rdata), 32'd0);
    chk("rst_rsp", 32'(a_rsp), 32'd0);
    chk("rst_drv", 32'(a_drv), 32'd0);

    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(a_ready), 32'd1);
    bad = 0;
    repeat (5) begin
      tick();
      if ({a_cs, a_oe, a_we_n} != 3'b111 || a_drv || !a_ready) bad++;
    end
    chk("idle_stable", 32'(bad), 32'd0);

    // Write 0x1A5A5 := 0xBEEF
    a_issue(1'b1, 18'h1A5A5, 16'hBEEF, 1'b0, w);
    chk("wr_wait", 32'(w), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("wr_ctl_c%0d", c), 32'({a_cs, a_oe, a_we_n}), 32'(wr_ctl[c]));
      chk($sformatf("wr_drv_c%0d", c), 32'(a_drv), 32'(wr_drv[c]));
      chk($sformatf("wr_rdy_c%0d", c), 32'(a_ready), 32'(wr_rdy[c]));
      chk($sformatf("wr_adr_c%0d", c), 32'(a_adr), 32'h1A5A5);
      if (c <= 4) chk($sformatf("wr_dat_c%0d", c), 32'(a_dat), 32'hBEEF);
      if (c < 5) tick();
    end

    // Read back 0x1A5A5
    a_issue(1'b0, 18'h1A5A5, 16'h0000, 1'b0, w);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("rd_ctl_c%0d", c), 32'({a_cs, a_oe, a_we_n}), 32'(rd_ctl[c]));
      chk($sformatf("rd_rsp_c%0d", c), 32'(a_rsp), 32'(rd_rsp[c]));
      chk($sformatf("rd_rdy_c%0d", c), 32'(a_ready), 32'(rd_rdy[c]));
      chk($sformatf("rd_drv_c%0d", c), 32'(a_drv), 32'd0);
      if (c <= 2) chk($sformatf("rd_adr_c%0d", c), 32'(a_adr), 32'h1A5A5);
      if (c >= 3) chk($sformatf("rd_data_c%0d", c), 32'(a_rdata), 32'hBEEF);
      if (c < 4) tick();
    end

    // Back-to-back: write then read with req_valid held high
    a_issue(1'b1, 18'h00F0F, 16'h1234, 1'b1, w);
    a_issue(1'b0, 18'h00F0F, 16'h0000, 1'b0, w);
    chk("b2b_wait", 32'(w), 32'd4);
    w = 0;
    while (!a_rsp && w < 40) begin tick(); w++; end
    chk("b2b_rsp_lat", 32'(w), 32'd2);
    chk("b2b_rdata", 32'(a_rdata), 32'h1234);
    tick();

    // Reset during WR_PULSE
    a_issue(1'b1, 18'h2AAAA, 16'h5555, 1'b0, w);
    tick();
    chk("rstmid_in_pulse", 32'(a_we_n), 32'd0);
    rst = 1'b1;
    tick();
    chk("rstmid_ctl", 32'({a_cs, a_oe, a_we_n}), 32'b111);
    chk("rstmid_drv", 32'(a_drv), 32'd0);
    chk("rstmid_ready", 32'(a_ready), 32'd0);
    chk("rstmid_rsp", 32'(a_rsp), 32'd0);
    rst = 1'b0;
    tick();
    chk("rstmid_ready_back", 32'(a_ready), 32'd1);
    repeat (3) tick();
    chk("rsp_count", 32'(a_rsp_cnt), 32'd2);
    chk("no_contention", 32'(a_bad), 32'd0);

    // WAIT_CYCLES = 1
    bc_op(1'b0, 1'b1, 18'h00123, 16'hCAFE, rd, ok);
    chk("w1_wr_ok", 32'(ok), 32'd1);
    chk("w1_we_width", 32'(b_we_w), 32'd1);
    bc_op(1'b0, 1'b0, 18'h00123, 16'h0000, rd, ok);
    chk("w1_rd_ok", 32'(ok), 32'd1);
    chk("w1_oe_width", 32'(b_oe_w), 32'd1);
    chk("w1_rdata", 32'(rd), 32'h5B79);

    // WAIT_CYCLES = 15
    bc_op(1'b1, 1'b1, 18'h3C0DE, 16'hF00D, rd, ok);
    chk("w15_wr_ok", 32'(ok), 32'd1);
    chk("w15_we_width", 32'(c_we_w), 32'd15);
    bc_op(1'b1, 1'b0, 18'h3C0DE, 16'h0000, rd, ok);
    chk("w15_rd_ok", 32'(ok), 32'd1);
    chk("w15_oe_width", 32'(c_oe_w), 32'd15);
    chk("w15_rdata", 32'(rd), 32'h9A84);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
